id_ex_pipe: RTL

//  ID/EX pipeline register of the 5-stage MIPS core, directly downstream of the register file.
//  - Captures the two register-file read ports plus the decoded fields and control of the ID-stage instruction.
//  - Presents them to EX one cycle later.
//  - Owns load-use hazard detection: stalls IF/ID and injects a bubble when required.
//  - Honours a hold request from a multi-cycle EX unit and a flush request from branch/jump resolution.
//  - Keeps a saturating count of inserted bubbles.

---
 rtl/id_ex_pipe_pkg.sv | 30 +++
 rtl/id_ex_pipe_hazard_unit.sv | 30 +++
 rtl/id_ex_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/id_ex_pipe_pkg.sv
// Shared types and control-bit indices for the ID/EX pipeline register.
// Field layout of the decoded control bundle used by ID and EX.
package id_ex_pipe_pkg;

  localparam int CTRL_W = 16;
  localparam int BCNT_W = 16;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 5;
  localparam int CTRL_JAL        = 6;
  localparam int CTRL_SYSCALL    = 7;
  localparam int CTRL_ALU_OP_LO  = 8;
  localparam int CTRL_ALU_OP_HI  = 11;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
  } id_ex_t;

endpackage

// File: rtl/id_ex_pipe_hazard_unit.sv
// Load-use hazard detection for the ID/EX boundary.
// Purely combinational; drives the IF/ID freeze.
module id_ex_pipe_hazard_unit (
  input  logic       rst,
  input  logic       flush,
  input  logic       ex_stall,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       hz,
  output logic       stall_if_id
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = id_uses_rt & (ex_rt == id_rt);

  // $zero is never a real producer, so it cannot cause a load-use stall
  assign hz = ex_valid & ex_mem_read & (ex_rt != 5'd0)
            & id_valid & (rs_hit | rt_hit);

  assign stall_if_id = ~rst & ~flush & (ex_stall | hz);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion,
// EX hold, branch flush and a saturating bubble counter.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int BCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic [31:0]       id_imm,
  input  logic [31:0]       id_pc_plus_4,
  input  logic [31:0]       id_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       rf_rd1,
  input  logic [31:0]       rf_rd2,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_pc_plus_4,
  output logic [31:0]       ex_instr,
  output logic [31:0]       ex_rd1,
  output logic [31:0]       ex_rd2,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [BCNT_W-1:0] bubble_count
);

  id_ex_t            bank;
  id_ex_t            bank_in;
  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic              hz;

  id_ex_pipe_hazard_unit u_hazard (
    .rst         (rst),
    .flush       (flush),
    .ex_stall    (ex_stall),
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q[CTRL_MEM_READ]),
    .ex_rt       (bank.rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .hz          (hz),
    .stall_if_id (stall_if_id)
  );

  assign bank_in = '{
    rs:        id_rs,
    rt:        id_rt,
    rd:        id_rd,
    imm:       id_imm,
    pc_plus_4: id_pc_plus_4,
    instr:     id_instr,
    rd1:       rf_rd1,
    rd2:       rf_rd2
  };

  always_ff @(posedge clk) begin
    if (rst) begin
      bank    <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      bcnt_q  <= '0;
    end else if (flush) begin
      bank    <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (ex_stall) begin
      bank    <= bank;
      valid_q <= valid_q;
      ctrl_q  <= ctrl_q;
    end else if (hz) begin
      bank    <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      if (bcnt_q != '1)
        bcnt_q <= bcnt_q + 1'b1;
    end else begin
      bank    <= bank_in;
      valid_q <= id_valid;
      ctrl_q  <= id_valid ? id_ctrl : '0;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_rs        = bank.rs;
  assign ex_rt        = bank.rt;
  assign ex_rd        = bank.rd;
  assign ex_imm       = bank.imm;
  assign ex_pc_plus_4 = bank.pc_plus_4;
  assign ex_instr     = bank.instr;
  assign ex_rd1       = bank.rd1;
  assign ex_rd2       = bank.rd2;
  assign bubble_count = bcnt_q;

endmodule
